// File: rtl/node_mac_seq.sv
// Serial multiply-accumulate neuron: N_INPUTS float activations times loadable weights, plus bias.
// Define NODE_MAC_RELU_EN to clamp negative results (including -0.0) to +0.0; otherwise the output is linear.

// Single-precision multiply: denormal inputs read as zero, truncating round, underflow to zero, overflow to inf.
module float_mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [47:0]       p;
    logic signed [9:0] e;

    always_comb begin
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
            + (p[47] ? 10'sd1 : 10'sd0);
        y = {a[31] ^ b[31], 31'd0};
        if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
            if (e >= 10'sd255)
                y[30:23] = 8'hff;
            else if (e > 10'sd0)
                y[30:0] = {e[7:0], p[47] ? p[46:24] : p[45:23]};
        end
    end
endmodule

// Single-precision add: same zero/denormal/rounding behaviour as float_mult.
module float_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [31:0] big, sml;
    logic [7:0]  d, e;
    logic [24:0] mb, ms, s;

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        big = a;
        sml = b;
        if (a[30:0] < b[30:0]) begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        e  = big[30:23];
        mb = {2'b01, big[22:0]};
        ms = (d > 8'd24) ? 25'd0 : ({2'b01, sml[22:0]} >> d);
        s  = 25'd0;
        y  = 32'd0;
        if (a[30:23] == 8'd0) begin
            y = b;
        end else if (b[30:23] == 8'd0) begin
            y = a;
        end else if (big[31] == sml[31]) begin
            s = mb + ms;
            if (s[24]) begin
                s = s >> 1;
                e = e + 8'd1;
            end
            y = (e == 8'hff) ? {big[31], 8'hff, 23'd0} : {big[31], e, s[22:0]};
        end else begin
            s = mb - ms;
            for (int i = 0; i < 24; i++) begin
                if (s != 25'd0 && !s[23] && e > 8'd1) begin
                    s = s << 1;
                    e = e - 8'd1;
                end
            end
            y = s[23] ? {big[31], e, s[22:0]} : 32'd0;
        end
    end
endmodule

module node_mac_seq #(
    parameter int N_INPUTS = 15,
    parameter int ADDR_W   = $clog2(N_INPUTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [31:0]       w_data,
    output logic              cfg_busy,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       weight [N_INPUTS];
    logic [31:0]       bias, acc, prod_r, prod, sum, act;
    logic              prod_v, beat, last_beat, cfg_we;

    assign beat      = in_valid && in_ready;
    assign last_beat = (cnt == ADDR_W'(N_INPUTS - 1));
    assign cfg_busy  = (state != IDLE);
    assign cfg_we    = w_we && state == IDLE && cnt == '0;

    float_mult  u_mult (.a(in_data), .b(weight[cnt]), .y(prod));
    float_adder u_add  (.a(acc),     .b(prod_r),      .y(sum));

`ifdef NODE_MAC_RELU_EN
    assign act = sum[31] ? 32'd0 : sum;
`else
    assign act = sum;
`endif

    // NOTE: the weight store is reset because a frame after reset must see all-zero weights.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) weight[i] <= 32'd0;
            bias <= 32'd0;
        end else if (cfg_we) begin
            if (w_addr < ADDR_W'(N_INPUTS))
                weight[w_addr] <= w_data;
            else if (w_addr == ADDR_W'(N_INPUTS))
                bias <= w_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= 32'd0;
            prod_r    <= 32'd0;
            prod_v    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            in_ready  <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            prod_v    <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        prod_r <= prod;
                        prod_v <= 1'b1;
                        acc    <= bias;
                        cnt    <= ADDR_W'(1);
                        if (N_INPUTS == 1) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_v) acc <= sum;
                    prod_v <= beat;
                    if (beat) begin
                        prod_r <= prod;
                        cnt    <= cnt + 1'b1;
                        if (last_beat) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                // Last product folds straight into the output register rather than into acc.
                DRAIN: begin
                    out_data  <= act;
                    out_valid <= 1'b1;
                    prod_v    <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
